aesl_deadlock_watchdog: RTL and testbench

AESL_DEADLOCK_WATCHDOG -- requirements
Module: aesl_deadlock_watchdog

---
 rtl/aesl_deadlock_watchdog.sv | 126 ++++++++++++
 tb/tb_aesl_deadlock_watchdog.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/aesl_deadlock_watchdog.sv
// Deadlock watchdog: confirms a deadlock once the monitor's blocked flag stays high with an
// unchanged channel bitmap for THRESHOLD consecutive cycles, then holds a report until consumed.
module aesl_deadlock_watchdog #(
   parameter int unsigned THRESHOLD = 1000,
   parameter int unsigned INFO_W    = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              block,
   input  logic [INFO_W-1:0] axis_block_info,
   input  logic              clear,
   input  logic              report_ready,
   output logic              suspect,
   output logic              deadlock,
   output logic              report_valid,
   output logic [INFO_W-1:0] report_info,
   output logic [15:0]       stall_cycles,
   output logic [7:0]        episodes
);

   localparam int unsigned STALL_W = 16;
   localparam int unsigned EPI_W   = 8;
   localparam logic [STALL_W-1:0] THR    = STALL_W'(THRESHOLD);
   localparam logic [STALL_W-1:0] THR_M1 = STALL_W'(THRESHOLD - 1);
   localparam logic [EPI_W-1:0]   EPI_MAX = '1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SUSPECT   = 2'd1,
      CONFIRMED = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [STALL_W-1:0]  stall_q, stall_d;
   logic [INFO_W-1:0]   snap_q, snap_d;
   logic [INFO_W-1:0]   info_q, info_d;
   logic                dead_q, dead_d;
   logic [EPI_W-1:0]    epi_q, epi_d;
   logic                suspect_q, valid_q;

   // State register; suspect/report_valid are registered decodes of the next state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         stall_q   <= '0;
         snap_q    <= '0;
         info_q    <= '0;
         dead_q    <= 1'b0;
         epi_q     <= '0;
         suspect_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         stall_q   <= stall_d;
         snap_q    <= snap_d;
         info_q    <= info_d;
         dead_q    <= dead_d;
         epi_q     <= epi_d;
         suspect_q <= (state_d == SUSPECT);
         valid_q   <= (state_d == CONFIRMED);
      end
   end

   // Next-state and datapath; clear overrides every other event
   always_comb begin
      state_d = state_q;
      stall_d = stall_q;
      snap_d  = snap_q;
      info_d  = info_q;
      dead_d  = dead_q;
      epi_d   = epi_q;
      if (clear) begin
         state_d = IDLE;
         stall_d = '0;
         snap_d  = '0;
         info_d  = '0;
         dead_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (block) begin
                  state_d = SUSPECT;
                  stall_d = STALL_W'(1);
                  snap_d  = axis_block_info;
                  if (epi_q != EPI_MAX) epi_d = epi_q + EPI_W'(1);
               end else begin
                  stall_d = '0;
               end
            end
            SUSPECT: begin
               if (!block) begin
                  state_d = IDLE;
                  stall_d = '0;
               end else if (axis_block_info != snap_q) begin
                  // Bitmap moved: the pipeline made progress, restart the count
                  stall_d = STALL_W'(1);
                  snap_d  = axis_block_info;
               end else if (stall_q == THR_M1) begin
                  state_d = CONFIRMED;
                  stall_d = THR;
                  dead_d  = 1'b1;
                  info_d  = snap_q;
               end else begin
                  stall_d = stall_q + STALL_W'(1);
               end
            end
            CONFIRMED: begin
               if (report_ready) state_d = DONE;
            end
            DONE: begin
               state_d = DONE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign suspect      = suspect_q;
   assign deadlock     = dead_q;
   assign report_valid = valid_q;
   assign report_info  = info_q;
   assign stall_cycles = stall_q;
   assign episodes     = epi_q;

endmodule

// File: tb/tb_aesl_deadlock_watchdog.sv
// Directed-vector bench for aesl_deadlock_watchdog with THRESHOLD=8, INFO_W=4.
module tb_aesl_deadlock_watchdog;

   localparam int unsigned THR = 8;
   localparam int unsigned IW  = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          block = 1'b0;
   logic [IW-1:0] axis_block_info = '0;
   logic          clear = 1'b0;
   logic          report_ready = 1'b0;
   logic          suspect, deadlock, report_valid;
   logic [IW-1:0] report_info;
   logic [15:0]   stall_cycles;
   logic [7:0]    episodes;

   aesl_deadlock_watchdog #(.THRESHOLD(THR), .INFO_W(IW)) dut (
      .clock(clock), .reset_n(reset_n), .block(block), .axis_block_info(axis_block_info),
      .clear(clear), .report_ready(report_ready), .suspect(suspect), .deadlock(deadlock),
      .report_valid(report_valid), .report_info(report_info), .stall_cycles(stall_cycles),
      .episodes(episodes)
   );

   always #5 clock = ~clock;

   // {suspect, deadlock, report_valid, report_info, stall_cycles, episodes}
   typedef struct {
      logic          b;
      logic [IW-1:0] i;
      logic          clr;
      logic          rdy;
      logic [30:0]   exp;
      string         nm;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   failures = 0;

   wire [30:0] act = {suspect, deadlock, report_valid, report_info, stall_cycles, episodes};

   function automatic logic [30:0] pk(input logic s, input logic d, input logic v,
                                      input logic [3:0] ri, input logic [15:0] st,
                                      input logic [7:0] ep);
      return {s, d, v, ri, st, ep};
   endfunction

   function automatic void add(input string nm, input logic b, input logic [3:0] i,
                               input logic clr, input logic rdy, input logic [30:0] e);
      vec_t v;
      v.b = b; v.i = i; v.clr = clr; v.rdy = rdy; v.exp = e; v.nm = nm;
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [30:0] a, input logic [30:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual{sus,dl,vld,info,stall,ep}=%b_%b_%b_%h_%0d_%0d required=%b_%b_%b_%h_%0d_%0d",
                  nm, a[30], a[29], a[28], a[27:24], a[23:8], a[7:0],
                  e[30], e[29], e[28], e[27:24], e[23:8], e[7:0]);
      end
   endtask

   task automatic step(input logic b, input logic [3:0] i, input logic clr, input logic rdy);
      @(negedge clock);
      block = b; axis_block_info = i; clear = clr; report_ready = rdy;
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Full confirm with info A
      for (int k = 1; k <= 7; k++) add("confirm_A", 1, 4'hA, 0, 0, pk(1, 0, 0, 4'h0, 16'(k), 8'd1));
      add("confirm_A_edge8", 1, 4'hA, 0, 0, pk(0, 1, 1, 4'hA, 16'd8, 8'd1));
      // Report held without ready, block ignored
      for (int k = 0; k < 10; k++) add("hold_valid", k[0], 4'h3, 0, 0, pk(0, 1, 1, 4'hA, 16'd8, 8'd1));
      add("ready_done", 1, 4'h3, 0, 1, pk(0, 1, 0, 4'hA, 16'd8, 8'd1));
      add("done_hold", 1, 4'h7, 0, 0, pk(0, 1, 0, 4'hA, 16'd8, 8'd1));
      add("done_hold2", 0, 4'h7, 0, 1, pk(0, 1, 0, 4'hA, 16'd8, 8'd1));
      add("clear_done", 0, 4'h0, 1, 0, pk(0, 0, 0, 4'h0, 16'd0, 8'd1));
      // Re-confirm, then clear together with ready
      for (int k = 1; k <= 7; k++) add("confirm_5", 1, 4'h5, 0, 0, pk(1, 0, 0, 4'h0, 16'(k), 8'd2));
      add("confirm_5_edge8", 1, 4'h5, 0, 0, pk(0, 1, 1, 4'h5, 16'd8, 8'd2));
      add("clear_and_ready", 1, 4'h5, 1, 1, pk(0, 0, 0, 4'h0, 16'd0, 8'd2));
      // Two 7-cycle runs broken by one idle cycle
      for (int k = 1; k <= 7; k++) add("run1", 1, 4'h1, 0, 0, pk(1, 0, 0, 4'h0, 16'(k), 8'd3));
      add("gap", 0, 4'h1, 0, 0, pk(0, 0, 0, 4'h0, 16'd0, 8'd3));
      for (int k = 1; k <= 7; k++) add("run2", 1, 4'h1, 0, 0, pk(1, 0, 0, 4'h0, 16'(k), 8'd4));
      add("gap2", 0, 4'h1, 0, 0, pk(0, 0, 0, 4'h0, 16'd0, 8'd4));
      // Progress restart: info 2 for 5 edges, then 6
      for (int k = 1; k <= 5; k++) add("info2", 1, 4'h2, 0, 0, pk(1, 0, 0, 4'h0, 16'(k), 8'd5));
      for (int k = 1; k <= 7; k++) add("info6", 1, 4'h6, 0, 0, pk(1, 0, 0, 4'h0, 16'(k), 8'd5));
      add("info6_confirm", 1, 4'h6, 0, 0, pk(0, 1, 1, 4'h6, 16'd8, 8'd5));
      add("clear_conf", 0, 4'h0, 1, 0, pk(0, 0, 0, 4'h0, 16'd0, 8'd5));
      // Clear beats a confirming edge
      for (int k = 1; k <= 7; k++) add("pre_conf", 1, 4'h9, 0, 0, pk(1, 0, 0, 4'h0, 16'(k), 8'd6));
      add("clear_vs_confirm", 1, 4'h9, 1, 0, pk(0, 0, 0, 4'h0, 16'd0, 8'd6));
      add("idle_after_clear", 0, 4'h9, 0, 0, pk(0, 0, 0, 4'h0, 16'd0, 8'd6));

      // Reset state, asynchronous
      #2;
      chk("reset_state", act, 31'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("idle_after_reset", act, 31'd0);

      foreach (vq[n]) begin
         step(vq[n].b, vq[n].i, vq[n].clr, vq[n].rdy);
         chk($sformatf("%s[%0d]", vq[n].nm, n), act, vq[n].exp);
      end

      // Episode counter saturation
      for (int k = 0; k < 260; k++) begin
         step(1, 4'h4, 0, 0);
         step(0, 4'h4, 0, 0);
      end
      chk("episodes_sat", act, pk(0, 0, 0, 4'h0, 16'd0, 8'd255));
      step(1, 4'h4, 0, 0);
      chk("episodes_sat_hold", act, pk(1, 0, 0, 4'h0, 16'd1, 8'd255));

      // Asynchronous reset mid-SUSPECT
      step(0, 4'h0, 1, 0);
      for (int k = 1; k <= 5; k++) step(1, 4'h3, 0, 0);
      chk("pre_reset_stall5", act, pk(1, 0, 0, 4'h0, 16'd5, 8'd255));
      @(negedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_reset_mid", act, 31'd0);
      #1;
      reset_n = 1'b1;
      block = 1'b1; axis_block_info = 4'h3; clear = 1'b0; report_ready = 1'b0;
      @(posedge clock);
      #1;
      chk("new_episode", act, pk(1, 0, 0, 4'h0, 16'd1, 8'd1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
